axi_dram_slave: RTL
===================

# axi_dram_slave

Synthesizable AXI4 responder that sits at the far end of the image processor's `_s_inf` DRAM bus and serves its 128-bit INCR read and write bursts from an internal word array. It replaces the behavioural DRAM model so full-chip simulation and FPGA bring-up exercise a real cycle-accurate slave. The block has one independent read engine and one independent write engine, each with a single outstanding burst, plus a configurable read latency.

## Interface
- DEPTH, 1024: number of 128-bit words; byte address space is DEPTH*16.
- RD_LAT, 2: idle cycles between AR handshake and first R beat (0..15).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- awid_s_inf  in  4  write ID, captured on AW handshake.
- awaddr_s_inf  in  32  write start byte address.
- awsize_s_inf  in  3  must be 3'b100 (16 bytes).
- awburst_s_inf  in  2  must be 2'b01 (INCR).
- awlen_s_inf  in  8  beats minus one.
- awvalid_s_inf  in  1  AW request.
- awready_s_inf  out  1  AW accept.
- wdata_s_inf  in  128  write beat data.
- wlast_s_inf  in  1  master's last-beat flag.
- wvalid_s_inf  in  1  W beat valid.
- wready_s_inf  out  1  W beat accept.
- bid_s_inf  out  4  echoes captured awid.
- bresp_s_inf  out  2  2'b00 OKAY, 2'b10 SLVERR.
- bvalid_s_inf  out  1  write response valid.
- bready_s_inf  in  1  response accept.
- arid_s_inf  in  4  read ID.
- araddr_s_inf  in  32  read start byte address.
- arlen_s_inf  in  8  beats minus one.
- arsize_s_inf  in  3  must be 3'b100.
- arburst_s_inf  in  2  must be 2'b01.
- arvalid_s_inf  in  1  AR request.
- arready_s_inf  out  1  AR accept.
- rid_s_inf  out  4  echoes captured arid.
- rdata_s_inf  out  128  read beat data.
- rresp_s_inf  out  2  per-beat response.
- rlast_s_inf  out  1  final beat flag.
- rvalid_s_inf  out  1  R beat valid.
- rready_s_inf  in  1  R beat accept.

## Operation
- Word index = addr[31:4]; addr[3:0] ignored (treated aligned). Beat k of a burst accesses word index+k; index math is 28-bit, no wrap.
- Word out of range (index+k >= DEPTH): read beat returns rdata 0, rresp 2'b10; write beat discarded, burst bresp becomes 2'b10.
- Size != 3'b100 or burst != 2'b01: burst still runs all len+1 beats; every R beat rresp 2'b10, rdata 0; writes discarded, bresp 2'b10.
- Read FSM: R_IDLE (arready=1) -> AR handshake captures id/addr/len/err -> R_WAIT (RD_LAT cycles; skipped if RD_LAT=0) -> R_BURST (rvalid=1, rlast=1 when beat==len; advance on rvalid&rready; after last beat -> R_IDLE).
- Write FSM: W_IDLE (awready=1) -> AW handshake -> W_DATA (wready=1; each wvalid&wready writes one word, beat count++) -> after beat len -> W_RESP (bvalid=1 until bready) -> W_IDLE.
- Beat count, not wlast, ends the write burst; wlast mismatch (asserted early or absent on beat len) sets bresp 2'b10.
- Read and write engines run concurrently. Same-word read and write on the same edge: read returns pre-write data; write visible from the next cycle.
- Memory contents not cleared by rst.

## Timing
- Reset values: all outputs 0 (arready, awready, wready, rvalid, bvalid, rlast, resp, ids, rdata). Registered; arready/awready rise on the first rising edge after rst deasserts.
- AR handshake at edge T: arready low from T; first rvalid at edge T+RD_LAT+1; stalled rready holds rdata/rresp/rlast stable. Back-to-back beats with rready=1: one per cycle.
- After last R handshake at edge T: arready high from T (R_IDLE), next AR accepted earliest at T+1.
- AW handshake at T: wready high from T. Last W handshake at T2: wready low and bvalid high from T2. B handshake at T3: awready high from T3.
- rst mid-burst: both FSMs return to IDLE immediately, outputs to reset values; partially written words keep written data.
- Read combinational path: none from inputs to outputs; all outputs are flops.

## Test plan
- Write burst awaddr 0x100, awlen 3, data 0x..A0..A3 -> 4 beats accepted one per cycle, bvalid next cycle, bresp 0, bid = awid; then read araddr 0x100 arlen 3 -> rvalid at AR+3 (RD_LAT=2), data A0..A3, rlast on beat 3.
- Read with rready toggled 1,0,0,1 -> rdata held during stalls, no beat lost or duplicated, rid = arid 4'h5.
- Read araddr = (DEPTH-2)*16, arlen 3 -> beats 0,1 OKAY with data, beats 2,3 rresp 2'b10 rdata 0.
- Write with arsize 3'b011 (on AW: awsize 3'b011) awlen 1 -> memory unchanged, bresp 2'b10; wlast on beat 0 of a len-1 burst -> bresp 2'b10, both beats written.
- Simultaneous read and write bursts to same word 0x40 starting same cycle -> read returns old value on beat aligned with write edge, later reads return new value.
- Assert rst during R_BURST beat 1 -> rvalid/arready 0 immediately; arready 1 first edge after release; new read completes correctly.

Source files
------------

// File: rtl/axi_dram_slave_if.sv
// AXI4 bus bundle for the image processor's _s_inf DRAM port.
// The slave modport is the DRAM responder side, the master modport is the requester side.
interface axi_dram_slave_if;
    logic [3:0]   awid_s_inf;
    logic [31:0]  awaddr_s_inf;
    logic [2:0]   awsize_s_inf;
    logic [1:0]   awburst_s_inf;
    logic [7:0]   awlen_s_inf;
    logic         awvalid_s_inf;
    logic         awready_s_inf;
    logic [127:0] wdata_s_inf;
    logic         wlast_s_inf;
    logic         wvalid_s_inf;
    logic         wready_s_inf;
    logic [3:0]   bid_s_inf;
    logic [1:0]   bresp_s_inf;
    logic         bvalid_s_inf;
    logic         bready_s_inf;
    logic [3:0]   arid_s_inf;
    logic [31:0]  araddr_s_inf;
    logic [7:0]   arlen_s_inf;
    logic [2:0]   arsize_s_inf;
    logic [1:0]   arburst_s_inf;
    logic         arvalid_s_inf;
    logic         arready_s_inf;
    logic [3:0]   rid_s_inf;
    logic [127:0] rdata_s_inf;
    logic [1:0]   rresp_s_inf;
    logic         rlast_s_inf;
    logic         rvalid_s_inf;
    logic         rready_s_inf;

    modport slave (
        input  awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        output awready_s_inf,
        input  wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        output wready_s_inf,
        output bid_s_inf, bresp_s_inf, bvalid_s_inf,
        input  bready_s_inf,
        input  arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        output arready_s_inf,
        output rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        input  rready_s_inf
    );

    modport master (
        output awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        input  awready_s_inf,
        output wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        input  wready_s_inf,
        input  bid_s_inf, bresp_s_inf, bvalid_s_inf,
        output bready_s_inf,
        output arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        input  arready_s_inf,
        input  rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        output rready_s_inf
    );
endinterface

// File: rtl/axi_dram_slave.sv
// Cycle-accurate AXI4 DRAM responder: 128-bit INCR bursts served from an internal word array,
// with independent single-outstanding read and write engines and a configurable read latency.
module axi_dram_slave #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    axi_dram_slave_if.slave bus
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned IDX_W  = 28;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_WAIT  = 2'd1;
    localparam logic [1:0] R_BURST = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    // read engine state and registered outputs
    logic [1:0]        r_state, r_state_d;
    logic [3:0]        r_id, r_id_d;
    logic [IDX_W-1:0]  r_idx, r_idx_d;
    logic [LEN_W-1:0]  r_len, r_len_d;
    logic              r_err, r_err_d;
    logic [LEN_W-1:0]  r_beat, r_beat_d;
    logic [CNT_W-1:0]  r_cnt, r_cnt_d;
    logic              arready, arready_d;
    logic              rvalid, rvalid_d;
    logic              rlast, rlast_d;
    logic [DATA_W-1:0] rdata, rdata_d;
    logic [1:0]        rresp, rresp_d;

    logic [LEN_W-1:0]  ld_beat;
    logic [IDX_W-1:0]  ld_word;
    logic              ld_ok;
    logic [DATA_W-1:0] ld_data;

    // write engine state and registered outputs
    logic [1:0]        w_state, w_state_d;
    logic [3:0]        w_id, w_id_d;
    logic [IDX_W-1:0]  w_idx, w_idx_d;
    logic [LEN_W-1:0]  w_len, w_len_d;
    logic              w_err, w_err_d;
    logic              w_bad, w_bad_d;
    logic [LEN_W-1:0]  w_beat, w_beat_d;
    logic              awready, awready_d;
    logic              wready, wready_d;
    logic              bvalid, bvalid_d;
    logic [1:0]        bresp, bresp_d;

    logic [IDX_W-1:0]  w_word;
    logic              w_ok;
    logic              w_bad_now;
    logic              mem_we;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{bus.araddr_s_inf[3:0], bus.awaddr_s_inf[3:0]};

    // Read next-state: the beat being loaded is 0 from R_WAIT, beat+1 from R_BURST.
    always_comb begin
        r_state_d = r_state;
        r_id_d    = r_id;
        r_idx_d   = r_idx;
        r_len_d   = r_len;
        r_err_d   = r_err;
        r_beat_d  = r_beat;
        r_cnt_d   = r_cnt;
        arready_d = arready;
        rvalid_d  = rvalid;
        rlast_d   = rlast;
        rdata_d   = rdata;
        rresp_d   = rresp;

        ld_beat = (r_state == R_BURST) ? r_beat + LEN_W'(1) : LEN_W'(0);
        ld_word = r_idx + IDX_W'(ld_beat);
        ld_ok   = !r_err && (ld_word < IDX_W'(DEPTH));
        ld_data = ld_ok ? mem[ld_word[AW-1:0]] : '0;

        case (r_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (bus.arvalid_s_inf && arready) begin
                    r_id_d    = bus.arid_s_inf;
                    r_idx_d   = bus.araddr_s_inf[31:4];
                    r_len_d   = bus.arlen_s_inf;
                    r_err_d   = (bus.arsize_s_inf != 3'b100) || (bus.arburst_s_inf != 2'b01);
                    r_cnt_d   = CNT_W'(RD_LAT);
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt == '0) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = ld_data;
                    rresp_d   = ld_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = (r_len == '0);
                    r_beat_d  = '0;
                    r_state_d = R_BURST;
                end else begin
                    r_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            R_BURST: begin
                if (bus.rready_s_inf) begin
                    if (r_beat == r_len) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = ld_beat;
                        rdata_d  = ld_data;
                        rresp_d  = ld_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast_d  = (ld_beat == r_len);
                    end
                end
            end
            default: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
            r_beat  <= '0;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            r_state <= r_state_d;
            r_id    <= r_id_d;
            r_idx   <= r_idx_d;
            r_len   <= r_len_d;
            r_err   <= r_err_d;
            r_beat  <= r_beat_d;
            r_cnt   <= r_cnt_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rdata   <= rdata_d;
            rresp   <= rresp_d;
        end
    end

    // Write next-state: beat count, not wlast, closes the burst; any bad beat poisons bresp.
    always_comb begin
        w_state_d = w_state;
        w_id_d    = w_id;
        w_idx_d   = w_idx;
        w_len_d   = w_len;
        w_err_d   = w_err;
        w_bad_d   = w_bad;
        w_beat_d  = w_beat;
        awready_d = awready;
        wready_d  = wready;
        bvalid_d  = bvalid;
        bresp_d   = bresp;

        w_word    = w_idx + IDX_W'(w_beat);
        w_ok      = !w_err && (w_word < IDX_W'(DEPTH));
        w_bad_now = w_bad || !w_ok || (bus.wlast_s_inf != (w_beat == w_len));
        mem_we    = (w_state == W_DATA) && bus.wvalid_s_inf && wready && w_ok;

        case (w_state)
            W_IDLE: begin
                awready_d = 1'b1;
                if (bus.awvalid_s_inf && awready) begin
                    w_id_d    = bus.awid_s_inf;
                    w_idx_d   = bus.awaddr_s_inf[31:4];
                    w_len_d   = bus.awlen_s_inf;
                    w_err_d   = (bus.awsize_s_inf != 3'b100) || (bus.awburst_s_inf != 2'b01);
                    w_bad_d   = (bus.awsize_s_inf != 3'b100) || (bus.awburst_s_inf != 2'b01);
                    w_beat_d  = '0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid_s_inf && wready) begin
                    w_bad_d = w_bad_now;
                    if (w_beat == w_len) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_bad_now ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat + LEN_W'(1);
                    end
                end
            end
            W_RESP: begin
                if (bus.bready_s_inf) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_err   <= 1'b0;
            w_bad   <= 1'b0;
            w_beat  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= '0;
        end else begin
            w_state <= w_state_d;
            w_id    <= w_id_d;
            w_idx   <= w_idx_d;
            w_len   <= w_len_d;
            w_err   <= w_err_d;
            w_bad   <= w_bad_d;
            w_beat  <= w_beat_d;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            bresp   <= bresp_d;
        end
    end

    // Array has no reset so contents survive rst; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[w_word[AW-1:0]] <= bus.wdata_s_inf;
        end
    end

    assign bus.arready_s_inf = arready;
    assign bus.rid_s_inf     = r_id;
    assign bus.rdata_s_inf   = rdata;
    assign bus.rresp_s_inf   = rresp;
    assign bus.rlast_s_inf   = rlast;
    assign bus.rvalid_s_inf  = rvalid;
    assign bus.awready_s_inf = awready;
    assign bus.wready_s_inf  = wready;
    assign bus.bid_s_inf     = w_id;
    assign bus.bresp_s_inf   = bresp;
    assign bus.bvalid_s_inf  = bvalid;

endmodule
